// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 2;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    function automatic logic is_receiving(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write bus out of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs little-endian bytes into 32-bit words
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    logic [LANE_W-1:0] idx_q, idx_d;
    logic [23:0]       shift_q, shift_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Older bytes slide toward bit 0, so byte 0 lands in [7:0] once the fourth arrives.
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            idx_d   = idx_q + LANE_W'(1);
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    assign word_valid = byte_valid && !clear && (idx_q == LAST_LANE);
    assign word_data  = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - writes a length/checksum framed byte image into instruction memory
// and holds the core in reset until a good image has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int          CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
    logic [WORD_W-1:0]   imem_wdata_q, imem_wdata_d;

    logic                hs;
    logic                data_hs;
    logic                rearm;
    logic                last_word;
    logic                word_valid;
    logic [WORD_W-1:0]   word_data;
    logic [LEN_W-1:0]    len_full;

    assign hs        = bus.in_valid && busy;
    assign data_hs   = hs && (state_q == ST_DATA);
    assign rearm     = start && ((state_q == ST_DONE) || (state_q == ST_ERR));
    assign len_full  = {bus.in_data, len_q[7:0]};
    assign last_word = (32'(wcnt_q) + 32'd1) == 32'(len_q);

    imem_loader_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (rearm),
        .byte_valid (data_hs),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN_LO: if (hs) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (hs) begin
                    if (len_full == '0)                 state_d = ST_CSUM;
                    else if (32'(len_full) > DEPTH)     state_d = ST_ERR;
                    else                                state_d = ST_DATA;
                end
            end
            ST_DATA:   if (word_valid && last_word) state_d = ST_CSUM;
            ST_CSUM:   if (hs) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
            ST_DONE,
            ST_ERR:    if (start) state_d = ST_LEN_LO;
            default:   state_d = ST_LEN_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= '0;
            wcnt_q       <= '0;
            csum_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= '0;
        end else begin
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            csum_q       <= csum_d;
            imem_we_q    <= imem_we_d;
            imem_waddr_q <= imem_waddr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    // Address/data registers only move on a completed word so they hold between writes.
    always_comb begin
        len_d        = len_q;
        wcnt_d       = wcnt_q;
        csum_d       = csum_q;
        imem_we_d    = 1'b0;
        imem_waddr_d = imem_waddr_q;
        imem_wdata_d = imem_wdata_q;
        if (rearm) begin
            len_d  = '0;
            wcnt_d = '0;
            csum_d = '0;
        end
        if (hs && (state_q == ST_LEN_LO)) len_d[7:0] = bus.in_data;
        if (hs && (state_q == ST_LEN_HI)) len_d = len_full;
        if (data_hs) csum_d = csum_q ^ bus.in_data;
        if (word_valid) begin
            wcnt_d       = wcnt_q + CNT_W'(1);
            imem_we_d    = 1'b1;
            imem_waddr_d = wcnt_q[ADDR_W-1:0];
            imem_wdata_d = word_data;
        end
    end

    always_comb begin
        busy     = is_receiving(state_q);
        core_rst = (state_q != ST_DONE);
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_ERR);
    end

    assign bus.in_ready   = busy;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_waddr = imem_waddr_q;
    assign bus.imem_wdata = imem_wdata_q;

endmodule
